// File: rtl/fifo_rd_stream.sv
// Bridges a non-showahead FIFO read port onto a valid/ready stream with packet framing.
// A 3-entry skid buffer absorbs the two-cycle read latency so full throughput survives backpressure.
module fifo_rd_stream #(
  parameter int DWIDTH  = 8,
  parameter int PKT_LEN = 4
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              fifo_empty_i,
  input  logic [DWIDTH-1:0] fifo_q_i,
  output logic              fifo_rd_req_o,
  output logic [DWIDTH-1:0] src_data_o,
  output logic              src_valid_o,
  output logic              src_last_o,
  input  logic              src_ready_i,
  output logic [15:0]       pkt_cnt_o
);

  if (PKT_LEN < 1 || PKT_LEN > 65535) begin : g_bad_pkt_len
    $error("fifo_rd_stream: PKT_LEN must be in 1..65535");
  end

  localparam logic [15:0] LAST_BEAT = 16'(PKT_LEN - 1);
  localparam int          DEPTH     = 3;

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [1:0]        wr_ptr;
  logic [1:0]        rd_ptr;
  logic [1:0]        occ;
  logic              infl;
  logic [15:0]       beat;
  logic [15:0]       pkt_cnt;
  logic              push;
  logic              pop;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'(DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction

  // A request is only issued when the slot it will land in is already
  // guaranteed free, counting the word still in flight from last cycle.
  assign fifo_rd_req_o = srst_i && !fifo_empty_i
                         && (({1'b0, occ} + {2'b00, infl}) < 3'(DEPTH));

  assign push        = infl;
  assign src_valid_o = (occ != 2'd0);
  assign pop         = src_valid_o && src_ready_i;
  assign src_data_o  = src_valid_o ? mem[rd_ptr] : '0;
  assign src_last_o  = src_valid_o && (beat == LAST_BEAT);
  assign pkt_cnt_o   = pkt_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk_i or negedge srst_i) begin
    if (!srst_i) begin
      occ     <= 2'd0;
      infl    <= 1'b0;
      wr_ptr  <= 2'd0;
      rd_ptr  <= 2'd0;
      beat    <= 16'd0;
      pkt_cnt <= 16'd0;
    end else begin
      infl <= fifo_rd_req_o;
      occ  <= occ + {1'b0, push} - {1'b0, pop};
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
        beat   <= (beat == LAST_BEAT) ? 16'd0 : beat + 16'd1;
        if (src_last_o) pkt_cnt <= pkt_cnt + 16'd1;
      end
    end
  end

  // NOTE: the storage array carries no reset; occupancy and pointers are reset,
  // and src_data_o is masked while empty, so stale contents are never visible.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= fifo_q_i;
  end

  a_no_overflow : assert property (@(posedge clk_i) disable iff (!srst_i)
    !(push && !pop && occ == 2'(DEPTH)));

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream: a behavioural non-showahead FIFO feeds the DUT,
// expected beats, timings and counts are hand-derived constants.
module tb_fifo_rd_stream;

  logic        clk = 1'b0;
  logic        srst;
  logic        fifo_empty;
  logic [7:0]  fifo_q;
  logic        fifo_rd_req;
  logic [7:0]  src_data;
  logic        src_valid;
  logic        src_last;
  logic        src_ready;
  logic [15:0] pkt_cnt;

  logic        empty1;
  logic [7:0]  q1;
  logic        rd_req1;
  logic [7:0]  data1;
  logic        valid1;
  logic        last1;
  logic        ready1;
  logic [15:0] pkt_cnt1;

  int n_total = 0;
  int n_bad   = 0;

  logic [7:0] fifo_data [0:127];
  int         fifo_wr = 0;
  int         fifo_rd = 0;
  logic       flush = 1'b0;

  always #5 clk = ~clk;

  fifo_rd_stream #(.DWIDTH(8), .PKT_LEN(4)) u_dut (
    .clk_i(clk), .srst_i(srst), .fifo_empty_i(fifo_empty), .fifo_q_i(fifo_q),
    .fifo_rd_req_o(fifo_rd_req), .src_data_o(src_data), .src_valid_o(src_valid),
    .src_last_o(src_last), .src_ready_i(src_ready), .pkt_cnt_o(pkt_cnt)
  );

  fifo_rd_stream #(.DWIDTH(8), .PKT_LEN(1)) u_dut1 (
    .clk_i(clk), .srst_i(srst), .fifo_empty_i(empty1), .fifo_q_i(q1),
    .fifo_rd_req_o(rd_req1), .src_data_o(data1), .src_valid_o(valid1),
    .src_last_o(last1), .src_ready_i(ready1), .pkt_cnt_o(pkt_cnt1)
  );

  // Upstream FIFO model: word appears on fifo_q the cycle after a request.
  assign fifo_empty = (fifo_rd == fifo_wr);
  always @(posedge clk) begin
    if (flush) begin
      fifo_rd <= fifo_wr;
    end else if (fifo_rd_req && (fifo_rd != fifo_wr)) begin
      fifo_q  <= fifo_data[fifo_rd];
      fifo_rd <= fifo_rd + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      fifo_data[fifo_wr] = first + 8'(i);
      fifo_wr = fifo_wr + 1;
    end
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #2;
    srst      = 1'b0;
    src_ready = 1'b0;
    flush     = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    flush = 1'b0;
    srst  = 1'b1;
  endtask

  // Collect n beats (consecutive values from first), checking order, framing
  // and output stability on stalled cycles. mode 0: ready high, 1: toggling.
  task automatic collect(input string name, input int n, input logic [7:0] first, input int mode);
    int   got = 0;
    logic prev_stall = 1'b0;
    logic [7:0] prev_data = '0;
    logic prev_last = 1'b0;
    for (int c = 0; c < 20 * n + 20 && got < n; c++) begin
      src_ready = (mode == 0) ? 1'b1 : ((c % 2) == 0);
      #1;
      if (prev_stall) begin
        check($sformatf("%s stall valid c%0d", name, c), src_valid, 1'b1);
        check($sformatf("%s stall data c%0d", name, c), src_data, prev_data);
        check($sformatf("%s stall last c%0d", name, c), src_last, prev_last);
      end
      if (src_valid && src_ready) begin
        check($sformatf("%s data beat%0d", name, got), src_data, first + 8'(got));
        check($sformatf("%s last beat%0d", name, got), src_last, (got % 4) == 3);
        got++;
      end
      prev_stall = src_valid && !src_ready;
      prev_data  = src_data;
      prev_last  = src_last;
      @(posedge clk);
      #1;
    end
    check($sformatf("%s beat count", name), got, n);
    src_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check($sformatf("%s drained", name), src_valid, 1'b0);
  endtask

  localparam logic [6:0] EXP_REQ   = 7'b000_1111;
  localparam logic [6:0] EXP_VALID = 7'b011_1100;
  localparam logic [6:0] EXP_LAST  = 7'b010_0000;

  initial begin
    logic [7:0] exp_data [7];
    int pulses;
    int hs;
    int nonlast;
    logic done;
    exp_data = '{8'h00, 8'h00, 8'h11, 8'h12, 8'h13, 8'h14, 8'h00};

    srst = 1'b0; src_ready = 1'b1; fifo_q = '0;
    empty1 = 1'b1; q1 = 8'h5A; ready1 = 1'b0;

    // Reset held with a non-empty FIFO: no request, all outputs quiet.
    preload(8'h11, 4);
    repeat (2) @(posedge clk);
    #2;
    check("rst rd_req", fifo_rd_req, 1'b0);
    check("rst valid", src_valid, 1'b0);
    check("rst last", src_last, 1'b0);
    check("rst data", src_data, 8'h00);
    check("rst pkt_cnt", pkt_cnt, 16'h0);

    // Streaming, cycle-accurate.
    srst = 1'b1;
    #1;
    for (int c = 0; c < 7; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #3;
      end
      check($sformatf("stream rd_req c%0d", c), fifo_rd_req, EXP_REQ[c]);
      check($sformatf("stream valid c%0d", c), src_valid, EXP_VALID[c]);
      check($sformatf("stream last c%0d", c), src_last, EXP_LAST[c]);
      if (EXP_VALID[c]) check($sformatf("stream data c%0d", c), src_data, exp_data[c]);
    end
    check("stream pkt_cnt", pkt_cnt, 16'd1);

    // Backpressure: exactly three requests, head word held.
    apply_reset();
    preload(8'h11, 8);
    #1;
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #3;
      end
      if (fifo_rd_req) pulses++;
      if (c >= 2) check($sformatf("bp hold data c%0d", c), src_data, 8'h11);
    end
    check("bp rd_req pulses", pulses, 3);
    check("bp rd_req low", fifo_rd_req, 1'b0);
    check("bp valid", src_valid, 1'b1);
    collect("bp", 8, 8'h11, 0);
    check("bp pkt_cnt", pkt_cnt, 16'd2);

    // Ready toggling 1,0,1,0 over 12 words.
    apply_reset();
    preload(8'h21, 12);
    collect("tog", 12, 8'h21, 1);
    check("tog pkt_cnt", pkt_cnt, 16'd3);

    // Mid-packet asynchronous reset after two beats.
    apply_reset();
    preload(8'h01, 6);
    src_ready = 1'b1;
    hs = 0;
    for (int c = 0; c < 40 && hs < 2; c++) begin
      #1;
      if (src_valid) begin
        check($sformatf("mid data beat%0d", hs), src_data, 8'h01 + 8'(hs));
        hs++;
      end
      @(posedge clk);
      #1;
    end
    check("mid pre beats", hs, 2);
    check("mid pre valid", src_valid, 1'b1);
    #2;
    srst = 1'b0;
    #1;
    check("async rd_req", fifo_rd_req, 1'b0);
    check("async valid", src_valid, 1'b0);
    check("async last", src_last, 1'b0);
    check("async data", src_data, 8'h00);
    flush = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    flush = 1'b0;
    srst  = 1'b1;
    preload(8'hA0, 4);
    collect("mid", 4, 8'hA0, 0);
    check("mid pkt_cnt", pkt_cnt, 16'd1);

    // PKT_LEN=1 wrap: 65536 handshakes bring the packet counter back to 0.
    empty1 = 1'b0;
    ready1 = 1'b1;
    hs = 0;
    nonlast = 0;
    done = 1'b0;
    for (int c = 0; c < 70000 && !done; c++) begin
      @(posedge clk);
      #2;
      if (hs == 65536) begin
        check("wrap pkt_cnt 0", pkt_cnt1, 16'd0);
        done = 1'b1;
      end else begin
        if (hs == 65535) check("wrap pkt_cnt max", pkt_cnt1, 16'hFFFF);
        if (valid1) begin
          if (!last1) nonlast++;
          hs++;
        end
      end
    end
    ready1 = 1'b0;
    empty1 = 1'b1;
    check("wrap finished", done, 1'b1);
    check("wrap non-last beats", nonlast, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
